// File: rtl/spi_cfg_controller.sv
// Write-only SPI mode-0 target that deserialises 16-bit frames {wr, addr[6:0], data[7:0]}
// and commits them into the five PWM control registers, pulsing cfg_update on each commit.
module spi_cfg_controller #(
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       cfg_update
);

    // state  | meaning
    // IDLE   | waiting for a chip-select falling edge
    // SHIFT  | shifting copi in on each sclk rising edge
    // COMMIT | single cycle: apply the frame if it is a valid write
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [6:0] MAX_ADDR_W = 7'(MAX_ADDR);

    logic [1:0]  sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic        sclk_prev_q, ncs_prev_q;
    logic [1:0]  settle_q;
    logic        armed_q;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [7:0]  reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;
    logic        cfg_update_q;
    logic        wr_en;

    logic sclk_rise, ncs_rise, ncs_fall, copi_s;
    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign ncs_rise  = ncs_sync_q[1] & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_sync_q[1] & ncs_prev_q;
    assign copi_s    = copi_sync_q[1];

    // The ncs chain resets high, so a pin held low across reset would look like a falling
    // edge; armed_q only accepts a frame start once a real high level has been sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 2'b00;
            copi_sync_q <= 2'b00;
            ncs_sync_q  <= 2'b11;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            settle_q    <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            copi_sync_q <= {copi_sync_q[0], copi};
            ncs_sync_q  <= {ncs_sync_q[0], ncs};
            sclk_prev_q <= sclk_sync_q[1];
            ncs_prev_q  <= ncs_sync_q[1];
            settle_q    <= {settle_q[0], 1'b1};
            armed_q     <= armed_q | (settle_q[1] & ncs_sync_q[1]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall && armed_q) begin
                    state_d = SHIFT;
                    cnt_d   = 5'd0;
                    shreg_d = 16'h0000;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[14:0], copi_s};
                    if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                wr_en   = (cnt_q == 5'd16) && shreg_q[15] && (shreg_q[14:8] <= MAX_ADDR_W);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 5'd0;
            shreg_q      <= 16'h0000;
            reg0_q       <= 8'h00;
            reg1_q       <= 8'h00;
            reg2_q       <= 8'h00;
            reg3_q       <= 8'h00;
            reg4_q       <= 8'h00;
            cfg_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            cfg_update_q <= wr_en;
            if (wr_en) begin
                case (shreg_q[14:8])
                    7'd0:    reg0_q <= shreg_q[7:0];
                    7'd1:    reg1_q <= shreg_q[7:0];
                    7'd2:    reg2_q <= shreg_q[7:0];
                    7'd3:    reg3_q <= shreg_q[7:0];
                    7'd4:    reg4_q <= shreg_q[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = reg0_q;
    assign en_reg_out_15_8 = reg1_q;
    assign en_reg_pwm_7_0  = reg2_q;
    assign en_reg_pwm_15_8 = reg3_q;
    assign pwm_duty_cycle  = reg4_q;
    assign cfg_update      = cfg_update_q;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Scoreboard bench for spi_cfg_controller: frames are modelled as whole words, expected
// register snapshots and pulse times are queued, and a monitor checks every cfg_update pulse.
module tb_spi_cfg_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, copi, ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       cfg_update;

    spi_cfg_controller #(.MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .cfg_update      (cfg_update)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int expected_pulses = 0;

    logic [7:0]  m_regs [5];
    int          exp_cyc_q [$];
    logic [39:0] exp_regs_q [$];

    function automatic logic [39:0] model_pack();
        return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic [39:0] dut_pack();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    // A frame commits only if it is exactly 16 bits, a write, and addresses one of the five registers.
    function automatic void model_frame(input logic [31:0] bits, input int n, input int pulse_cyc);
        int addr;
        if (n != 16) return;
        if (bits[15] != 1'b1) return;
        addr = int'(bits[14:8]);
        if (addr > 4) return;
        m_regs[addr] = bits[7:0];
        exp_cyc_q.push_back(pulse_cyc);
        exp_regs_q.push_back(model_pack());
        expected_pulses++;
    endfunction

    always @(negedge clk) begin
        if (cfg_update === 1'b1) begin
            pulses++;
            checks++;
            if (exp_cyc_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: got pulse, required none", cyc);
            end else begin
                int          e_cyc;
                logic [39:0] e_regs;
                e_cyc  = exp_cyc_q.pop_front();
                e_regs = exp_regs_q.pop_front();
                if (cyc != e_cyc) begin
                    errors++;
                    $display("FAIL pulse_latency: got cycle %0d, required cycle %0d", cyc, e_cyc);
                end
                checks++;
                if (dut_pack() !== e_regs) begin
                    errors++;
                    $display("FAIL regs_at_pulse: got %h, required %h", dut_pack(), e_regs);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        copi = b;
        repeat (5) @(negedge clk);
        sclk = 1'b1;
        repeat (5) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input int gap);
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
        repeat (3) @(negedge clk);
        ncs = 1'b1;
        model_frame(bits, n, cyc + 4);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_phase(input string name);
        int budget;
        budget = 0;
        while (exp_cyc_q.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (exp_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_pulses: got %0d outstanding, required 0", name, exp_cyc_q.size());
            exp_cyc_q.delete();
            exp_regs_q.delete();
        end
        checks++;
        if (pulses != expected_pulses) begin
            errors++;
            $display("FAIL %s_pulse_count: got %0d, required %0d", name, pulses, expected_pulses);
        end
        checks++;
        if (dut_pack() !== model_pack()) begin
            errors++;
            $display("FAIL %s_regs: got %h, required %h", name, dut_pack(), model_pack());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] word;
        logic [6:0]  addr;
        int          n;

        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        rst  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_pack() !== 40'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h, required 0000000000", dut_pack());
        end
        checks++;
        if (cfg_update !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg_update: got %b, required 0", cfg_update);
        end
        repeat (4) @(negedge clk);

        send_frame(32'h80F0, 16, 6);
        send_frame(32'h81CC, 16, 6);
        send_frame(32'h8299, 16, 6);
        send_frame(32'h835A, 16, 6);
        send_frame(32'h8480, 16, 6);
        check_phase("basic");

        send_frame(32'h0455, 16, 6);
        send_frame(32'h8511, 16, 6);
        send_frame(32'hFF22, 16, 6);
        send_frame(32'h4199, 15, 6);
        send_frame(32'h10333, 17, 6);
        check_phase("discard");

        send_frame(32'h8410, 16, 3);
        send_frame(32'h8420, 16, 6);
        check_phase("back_to_back");

        word = 16'h82FF;
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 15; i >= 8; i--) send_bit(word[i]);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        @(negedge clk);
        checks++;
        if (dut_pack() !== 40'h0) begin
            errors++;
            $display("FAIL midframe_reset_regs: got %h, required 0000000000", dut_pack());
        end
        for (int i = 7; i >= 0; i--) send_bit(word[i]);
        repeat (3) @(negedge clk);
        ncs = 1'b1;
        repeat (6) @(negedge clk);
        check_phase("midframe_reset");
        send_frame(32'h82A7, 16, 6);
        check_phase("after_reset");

        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
        check_phase("glitch");
        send_frame(32'h8163, 16, 6);
        check_phase("after_glitch");

        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 9))
                0:       n = 15;
                1:       n = 17;
                default: n = 16;
            endcase
            addr = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 6));
            word = {($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, addr, 8'($urandom)};
            send_frame({15'($urandom), word, 1'($urandom)} >> (17 - n), n, 3 + int'($urandom_range(0, 6)));
        end
        check_phase("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
